// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths, control bundle and ALU op encodings
package pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 4;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_NOR = 4'h5,
        ALU_SLT = 4'h6,
        ALU_SLL = 4'h7,
        ALU_SRL = 4'h8,
        ALU_SRA = 4'h9,
        ALU_LUI = 4'hA
    } alu_op_e;

    // Control bits that travel with an instruction; zeroed as a unit for bubbles.
    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and sync active-low clear
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low clear
//   en     : count one event this cycle
//   count  : current value, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall, flush and bubble counter
//   clk, rst_n       : clock, synchronous active-low reset
//   stall, flush     : hold stage / insert bubble (flush wins)
//   id_*             : decoded instruction fields from the ID stage
//   ex_*             : registered copies presented to EX
//   bubble_count     : saturating count of bubbles inserted since reset
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = pipe_pkg::DATA_W,
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int ALUOP_W    = pipe_pkg::ALUOP_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_ext_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [4:0]            id_shamt,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic [ALUOP_W-1:0]    id_alu_op,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_ext_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [4:0]            ex_shamt,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic [CNT_W-1:0]      bubble_count
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;

    always_comb begin
        id_ctrl            = '0;
        id_ctrl.reg_write  = id_reg_write;
        id_ctrl.mem_to_reg = id_mem_to_reg;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.mem_write  = id_mem_write;
        id_ctrl.branch     = id_branch;
        id_ctrl.alu_src    = id_alu_src;
        id_ctrl.reg_dst    = id_reg_dst;
        id_ctrl.alu_op     = id_alu_op;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            ex_valid    <= 1'b0;
            ex_pc_plus4 <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_ext_imm  <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_shamt    <= '0;
            ex_ctrl     <= '0;
        end else if (!stall) begin
            ex_valid    <= id_valid;
            ex_pc_plus4 <= id_pc_plus4;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_ext_imm  <= id_ext_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_shamt    <= id_shamt;
            // A non-valid slot must never write state downstream, so its
            // control bits are dropped while its data still flows through.
            ex_ctrl     <= id_valid ? id_ctrl : '0;
        end
    end

    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_reg_dst    = ex_ctrl.reg_dst;
    assign ex_alu_op     = ex_ctrl.alu_op;

    // A bubble is any edge that leaves EX empty: a flush, or an unstalled
    // load of a non-valid slot.
    logic bubble_en;
    assign bubble_en = flush || (!stall && !id_valid);

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bubble_en),
        .count (bubble_count)
    );

endmodule
